// File: rtl/aemb2_pkg.sv
// Shared definitions for the AEMB2 Wishbone arbiter: FSM state
// encodings and the grant codes presented on gnt_o.
package aemb2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        IGNT = 2'b01,
        DGNT = 2'b10
    } arb_state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_IWB  = 2'b01;
    localparam logic [1:0] GNT_DWB  = 2'b10;

endpackage

// File: rtl/aemb2_wbarb_tmo.sv
// Bus-cycle watchdog: a clear/enable up-counter whose terminal-count
// output flags that the current shared-bus cycle has run too long.
module aemb2_wbarb_tmo #(
    parameter int W = 8
) (
    input  logic gclk,
    input  logic grst,
    input  logic clr,
    input  logic ena,
    output logic tc
);

    logic [W-1:0] cnt;

    // Count cycles spent in a granted state; clear wins over enable.
    always_ff @(posedge gclk) begin
        if (grst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (ena) begin
            cnt <= cnt + W'(1);
        end
    end

    assign tc = &cnt;

endmodule

// File: rtl/aemb2_wbarb.sv
// Two-master round-robin arbiter merging the AEMB2 fetch (IWB) and
// data (DWB) ports onto one classic single-beat Wishbone master (XWB).
// Each grant is held until ack, requester abort, or watchdog timeout.
module aemb2_wbarb
    import aemb2_pkg::*;
#(
    parameter int AEMB_XWB = 32,
    parameter int AEMB_TMO = 8
) (
    input  logic                  gclk,
    input  logic                  grst,

    input  logic [AEMB_XWB-1:2]   iwb_adr_i,
    input  logic                  iwb_stb_i,
    input  logic                  iwb_cyc_i,
    output logic                  iwb_ack_o,
    output logic [31:0]           iwb_dat_o,

    input  logic [AEMB_XWB-1:2]   dwb_adr_i,
    input  logic                  dwb_stb_i,
    input  logic                  dwb_cyc_i,
    input  logic                  dwb_wre_i,
    input  logic [3:0]            dwb_sel_i,
    input  logic [31:0]           dwb_dat_i,
    output logic                  dwb_ack_o,
    output logic [31:0]           dwb_dat_o,

    output logic [AEMB_XWB-1:2]   xwb_adr_o,
    output logic                  xwb_stb_o,
    output logic                  xwb_cyc_o,
    output logic                  xwb_wre_o,
    output logic [3:0]            xwb_sel_o,
    output logic [31:0]           xwb_dat_o,
    input  logic                  xwb_ack_i,
    input  logic [31:0]           xwb_dat_i,

    output logic [1:0]            gnt_o,
    output logic                  tmo_o
);

    arb_state_t state;
    logic       lst_dwb;
    logic       ireq;
    logic       dreq;
    logic       cur_req;
    logic       grant;
    logic       tmo_tc;
    logic       tmo_fire;

    assign ireq    = iwb_stb_i & iwb_cyc_i;
    assign dreq    = dwb_stb_i & dwb_cyc_i;
    assign cur_req = (state == IGNT) ? ireq : dreq;
    assign grant   = (state == IDLE) & (ireq | dreq);

    aemb2_wbarb_tmo #(
        .W (AEMB_TMO)
    ) u_tmo (
        .gclk (gclk),
        .grst (grst),
        .clr  (grant),
        .ena  (state != IDLE),
        .tc   (tmo_tc)
    );

    // Arbitration FSM: grant in IDLE, hold until ack/abort/timeout, then
    // return to IDLE for at least one cycle before the next grant.
    always_ff @(posedge gclk) begin
        if (grst) begin
            state     <= IDLE;
            lst_dwb   <= 1'b0;
            xwb_stb_o <= 1'b0;
            xwb_wre_o <= 1'b0;
            xwb_adr_o <= '0;
            xwb_sel_o <= 4'h0;
            xwb_dat_o <= 32'h0;
            gnt_o     <= GNT_NONE;
            tmo_o     <= 1'b0;
        end else begin
            tmo_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (dreq && (!ireq || !lst_dwb)) begin
                        state     <= DGNT;
                        gnt_o     <= GNT_DWB;
                        xwb_stb_o <= 1'b1;
                        xwb_adr_o <= dwb_adr_i;
                        xwb_sel_o <= dwb_sel_i;
                        xwb_wre_o <= dwb_wre_i;
                        xwb_dat_o <= dwb_dat_i;
                    end else if (ireq) begin
                        state     <= IGNT;
                        gnt_o     <= GNT_IWB;
                        xwb_stb_o <= 1'b1;
                        xwb_adr_o <= iwb_adr_i;
                        xwb_sel_o <= 4'hF;
                        xwb_wre_o <= 1'b0;
                        xwb_dat_o <= 32'h0;
                    end
                end
                IGNT, DGNT: begin
                    if (!cur_req || xwb_ack_i || tmo_tc) begin
                        state     <= IDLE;
                        gnt_o     <= GNT_NONE;
                        xwb_stb_o <= 1'b0;
                        lst_dwb   <= (state == DGNT);
                        tmo_o     <= cur_req & ~xwb_ack_i & tmo_tc;
                    end
                end
                default: begin
                    state     <= IDLE;
                    gnt_o     <= GNT_NONE;
                    xwb_stb_o <= 1'b0;
                end
            endcase
        end
    end

    assign xwb_cyc_o = xwb_stb_o;

    // A real ack on the terminal-count cycle takes precedence over the
    // synthetic one, so read data is only zeroed for a genuine timeout.
    assign tmo_fire  = tmo_tc & ~xwb_ack_i;

    assign iwb_ack_o = (state == IGNT) & ireq & (xwb_ack_i | tmo_tc);
    assign dwb_ack_o = (state == DGNT) & dreq & (xwb_ack_i | tmo_tc);

    assign iwb_dat_o = ((state == IGNT) && tmo_fire) ? 32'h0 : xwb_dat_i;
    assign dwb_dat_o = ((state == DGNT) && tmo_fire) ? 32'h0 : xwb_dat_i;

endmodule
